// File: rtl/calc2_port_responder.sv
// Responder side of one CALC2 port: captures two-beat requests, queues them,
// and executes add/sub/shift in request order with a one-cycle response pulse.
module calc2_port_responder #(
    parameter int DEPTH     = 4,
    parameter int ADD_LAT   = 3,
    parameter int SHIFT_LAT = 2
) (
    input  logic        c_clk,
    input  logic        reset,
    input  logic [0:3]  req_cmd,
    input  logic [0:1]  req_tag,
    input  logic [0:31] req_data,
    output logic [0:1]  out_resp,
    output logic [0:31] out_data,
    output logic [0:1]  out_tag,
    output logic        err_drop
);

    localparam int DATA_W  = 32;
    localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int MAX_LAT = (ADD_LAT > SHIFT_LAT) ? ADD_LAT : SHIFT_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic { CAP_IDLE, CAP_OP2 } cap_state_t;
    typedef enum logic { EX_IDLE, EX_BUSY } ex_state_t;

    typedef struct packed {
        logic [3:0]        cmd;
        logic [1:0]        tag;
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
    } req_t;

    // Returns {resp, data}; any out-of-range result collapses to resp 2 / data 0.
    function automatic logic [DATA_W+1:0] alu_sat(input logic [3:0] cmd,
                                                  input logic [DATA_W-1:0] op1,
                                                  input logic [DATA_W-1:0] op2);
        logic [DATA_W:0] sum;
        sum     = {1'b0, op1} + {1'b0, op2};
        alu_sat = {2'd2, {DATA_W{1'b0}}};
        case (cmd)
            4'd1: if (!sum[DATA_W]) alu_sat = {2'd1, sum[DATA_W-1:0]};
            4'd2: if (op2 <= op1)   alu_sat = {2'd1, op1 - op2};
            4'd5: alu_sat = {2'd1, op1 << op2[4:0]};
            4'd6: alu_sat = {2'd1, op1 >> op2[4:0]};
            default: ;
        endcase
    endfunction

    function automatic logic is_shift(input logic [3:0] cmd);
        is_shift = (cmd == 4'd5) || (cmd == 4'd6);
    endfunction

    cap_state_t        cap_state, cap_next;
    ex_state_t         ex_state, ex_next;
    logic [3:0]        cmd_p0;
    logic [1:0]        tag_p0;
    logic [DATA_W-1:0] op1_p0;
    logic              vld_p0;
    req_t              mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       count;
    logic              full, push_ok, pop, fire;
    req_t              head, req_p1;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W+1:0] res_p1;

    // Stage p0: two-beat request capture
    always_comb begin
        cap_next = cap_state;
        vld_p0   = 1'b0;
        case (cap_state)
            CAP_IDLE: if (req_cmd != 4'd0) cap_next = CAP_OP2;
            CAP_OP2: begin
                vld_p0   = 1'b1;
                cap_next = CAP_IDLE;
            end
            default: cap_next = CAP_IDLE;
        endcase
    end

    always_ff @(posedge c_clk) begin
        if (cap_state == CAP_IDLE && req_cmd != 4'd0) begin
            cmd_p0 <= req_cmd;
            tag_p0 <= req_tag;
            op1_p0 <= req_data;
        end
    end

    // Queue: a push on a full queue survives only if the same edge pops
    assign full    = (count == FULL_CNT);
    assign head    = mem[rd_ptr];
    assign push_ok = vld_p0 && (!full || pop);

    always_ff @(posedge c_clk) begin
        if (push_ok) mem[wr_ptr] <= '{cmd: cmd_p0, tag: tag_p0, op1: op1_p0, op2: req_data};
        if (pop)     req_p1 <= head;
    end

    // Stage p1: execute with per-command latency
    always_comb begin
        ex_next = ex_state;
        pop     = 1'b0;
        fire    = 1'b0;
        case (ex_state)
            EX_IDLE: if (count != '0) begin
                pop     = 1'b1;
                ex_next = EX_BUSY;
            end
            EX_BUSY: if (cnt == '0) begin
                fire    = 1'b1;
                ex_next = EX_IDLE;
            end
            default: ex_next = EX_IDLE;
        endcase
    end

    assign res_p1 = alu_sat(req_p1.cmd, req_p1.op1, req_p1.op2);

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            cap_state <= CAP_IDLE;
            ex_state  <= EX_IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            cnt       <= '0;
            err_drop  <= 1'b0;
            out_resp  <= '0;
            out_data  <= '0;
            out_tag   <= '0;
        end else begin
            cap_state <= cap_next;
            ex_state  <= ex_next;
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            if (vld_p0 && full && !pop) err_drop <= 1'b1;
            if (pop)
                cnt <= is_shift(head.cmd) ? CNT_W'(SHIFT_LAT - 1) : CNT_W'(ADD_LAT - 1);
            else if (ex_state == EX_BUSY && cnt != '0)
                cnt <= cnt - 1'b1;
            // Stage p2: single-cycle response pulse
            if (fire) begin
                out_resp <= res_p1[DATA_W+1:DATA_W];
                out_data <= res_p1[DATA_W-1:0];
                out_tag  <= req_p1.tag;
            end else begin
                out_resp <= '0;
                out_data <= '0;
                out_tag  <= '0;
            end
        end
    end

endmodule
